// File: rtl/alu_pkg.sv
// Opcode encoding and constants shared by the round-robin ALU scheduler and its datapath.
package alu_pkg;

    localparam int OPW = 4;

    typedef logic [OPW-1:0] op_t;

    localparam op_t OP_ADD = 4'd0;
    localparam op_t OP_SUB = 4'd1;
    localparam op_t OP_AND = 4'd2;
    localparam op_t OP_OR  = 4'd3;
    localparam op_t OP_XOR = 4'd4;
    localparam op_t OP_NOR = 4'd5;
    localparam op_t OP_SLT = 4'd6;
    localparam op_t OP_SLL = 4'd7;
    localparam op_t OP_SRL = 4'd8;

    // Illegal opcodes (9..15) produce a result with every bit set to this value.
    localparam logic ILLEGAL_FILL = 1'b0;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU shared by all requesters; signed-overflow output exists
// only when ALU_RR_SCHED_FLAGS_EN is defined.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] z
`ifdef ALU_RR_SCHED_FLAGS_EN
    ,
    output logic             ovf
`endif
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;

    assign sum   = a + b;
    assign diff  = a - b;
    assign shamt = b[SHW-1:0];

    // NOTE: every output of a combinational block gets a default before the case,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        z = {WIDTH{ILLEGAL_FILL}};
        case (op)
            OP_ADD:  z = sum;
            OP_SUB:  z = diff;
            OP_AND:  z = a & b;
            OP_OR:   z = a | b;
            OP_XOR:  z = a ^ b;
            OP_NOR:  z = ~(a | b);
            OP_SLT:  z = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL:  z = a << shamt;
            OP_SRL:  z = a >> shamt;
            default: z = {WIDTH{ILLEGAL_FILL}};
        endcase
    end

`ifdef ALU_RR_SCHED_FLAGS_EN
    always_comb begin
        ovf = 1'b0;
        case (op)
            OP_ADD:  ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            OP_SUB:  ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            default: ovf = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one alu_core among NREQ requesters, with a one-entry
// tagged result register. ALU_RR_SCHED_FLAGS_EN adds registered res_zero/res_ovf.
module alu_rr_sched
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [OPW*NREQ-1:0]   req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_data,
    output logic [IDW-1:0]        res_id,
    output logic [15:0]           op_count
`ifdef ALU_RR_SCHED_FLAGS_EN
    ,
    output logic                  res_zero,
    output logic                  res_ovf
`endif
);

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [IDW-1:0]   res_id_q, res_id_d;
    logic [15:0]      op_count_q, op_count_d;
    logic             ready_en_q;

    logic             free;
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic             accept;
    logic [OPW-1:0]   op_sel;
    logic [WIDTH-1:0] a_sel, b_sel, alu_z;

    assign free = !res_valid_q || res_ready;

    // First valid requester at or after the round-robin pointer, wrapping mod NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_found && req_valid[(int'(ptr_q) + i) % NREQ]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'((int'(ptr_q) + i) % NREQ);
            end
        end
    end

    // ready_en_q keeps every req_ready low until the first edge after reset release.
    assign req_ready = (ready_en_q && free && grant_found) ? (NREQ'(1) << grant_idx) : '0;
    assign accept    = |req_ready;

    always_comb begin
        op_sel = '0;
        a_sel  = '0;
        b_sel  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_idx == IDW'(k)) begin
                op_sel = req_op[OPW*k +: OPW];
                a_sel  = req_a[WIDTH*k +: WIDTH];
                b_sel  = req_b[WIDTH*k +: WIDTH];
            end
        end
    end

`ifdef ALU_RR_SCHED_FLAGS_EN
    logic alu_ovf;
    logic res_zero_q, res_zero_d;
    logic res_ovf_q, res_ovf_d;
`endif

    alu_core #(.WIDTH(WIDTH)) u_alu_core (
        .op (op_sel),
        .a  (a_sel),
        .b  (b_sel),
        .z  (alu_z)
`ifdef ALU_RR_SCHED_FLAGS_EN
        ,
        .ovf(alu_ovf)
`endif
    );

    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        ptr_d       = ptr_q;
        op_count_d  = op_count_q;
`ifdef ALU_RR_SCHED_FLAGS_EN
        res_zero_d  = res_zero_q;
        res_ovf_d   = res_ovf_q;
`endif
        if (accept) begin
            res_valid_d = 1'b1;
            res_data_d  = alu_z;
            res_id_d    = grant_idx;
            ptr_d       = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            op_count_d  = op_count_q + 16'd1;
`ifdef ALU_RR_SCHED_FLAGS_EN
            res_zero_d  = (alu_z == '0);
            res_ovf_d   = alu_ovf;
`endif
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            op_count_q  <= '0;
            ready_en_q  <= 1'b0;
`ifdef ALU_RR_SCHED_FLAGS_EN
            res_zero_q  <= 1'b0;
            res_ovf_q   <= 1'b0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            op_count_q  <= op_count_d;
            ready_en_q  <= 1'b1;
`ifdef ALU_RR_SCHED_FLAGS_EN
            res_zero_q  <= res_zero_d;
            res_ovf_q   <= res_ovf_d;
`endif
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign op_count  = op_count_q;
`ifdef ALU_RR_SCHED_FLAGS_EN
    assign res_zero  = res_zero_q;
    assign res_ovf   = res_ovf_q;
`endif

endmodule
